cipher_round_ctrl: RTL and testbench
====================================

Name: cipher_round_ctrl

Overview:
Multi-round 8-bit byte cipher sequencer built around one shared instance of the existing combinational `substitution_block` (8-bit S-box).
- Accepts a data byte and a key byte over a valid/ready handshake.
- Runs ROUNDS iterations of key-mix plus substitute, one round per clock.
- Applies post-whitening and presents the result on a valid/ready output port.
- Sits between the UART/byte front-end and the result register in the cryptosystem top level.

Parameters:
ROUNDS, 4, number of substitution rounds; legal range 1..15; elaboration error outside this range.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  data_in/key_in valid.
- in_ready  out  1  block can accept a new byte.
- data_in  in  8  plaintext byte.
- key_in  in  8  key byte; sampled with data_in.
- out_valid  out  1  data_out valid.
- out_ready  in  1  downstream accepts data_out.
- data_out  out  8  cipher result.
- busy  out  1  high in ROUND or DONE.

Behaviour:
- Reset: synchronous and active-high; one clock, `clk`. When rst=1 at a rising edge:
  - state=IDLE.
  - in_ready=1, out_valid=0, busy=0.
  - data_out=8'h00, round counter=0, internal state/key registers=0.
- Reset mid-operation aborts the current byte; no output is produced for it.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch st<=data_in and k<=key_in, clear r to 0, go to ROUND.
- State ROUND:
  - in_ready=0.
  - Each cycle: st <= substitution_block(st ^ rotl(k, r mod 8)); r <= r+1.
  - After the update with r==ROUNDS-1, go to DONE and load data_out <= new_st ^ k.
- State DONE:
  - out_valid=1; data_out is held stable until accepted.
  - On out_ready, out_valid drops next cycle and the state returns to IDLE.
- Latency and throughput:
  - Accept edge to out_valid high: ROUNDS+1 cycles.
  - Minimum spacing between accepted bytes: ROUNDS+2 cycles.
- Round counter: width 4 bits; never wraps because ROUNDS<=15.
- rotl: 8-bit rotate left; the rotation amount wraps mod 8.
- Input handshake:
  - in_valid while in_ready=0 is ignored (not queued).
  - data_in/key_in changes outside the accept cycle have no effect.
- Output handshake:
  - out_ready while out_valid=0 is ignored.
  - out_ready held permanently high gives a one-cycle out_valid pulse.
- The same-cycle in_valid and out_ready corner cannot occur, because in_ready=0 in DONE.

Optional Feature:
Macro CIPHER_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in ROUND or DONE forces IDLE on the next edge: out_valid=0, data_out unchanged.
  - abort in IDLE has no effect.
  - abort has priority over out_ready; rst has priority over abort.
- Undefined: no abort port; behaviour is exactly as above.

Decomposition:
- Package cipher_pkg:
  - state enum {IDLE, ROUND, DONE} (2-bit encoding).
  - ROUNDS_MAX=15.
  - Function rotl8(byte, amount).
- Sub-module: the single `substitution_block` instance, fed combinationally from st ^ rotl8(k, r).
  - No other sub-modules.
- The FSM and datapath registers live in cipher_round_ctrl.

Test Plan:
1. ROUNDS=1, data_in=00, key_in=00, out_ready=1 -> data_out=52; out_valid high exactly 2 cycles after accept, for 1 cycle.
2. ROUNDS=1, data_in=00, key_in=01 -> data_out=08 (S(01)=09, then ^01). Same with data_in=63, key_in=00 -> data_out=00.
3. ROUNDS=4, data_in=00, key_in=00 -> state chain 52,48,D4,19 -> data_out=19; out_valid 5 cycles after accept.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and data_out stable, in_ready=0, second in_valid ignored; raise out_ready -> one transfer, then IDLE.
5. Reset: assert rst during the 2nd round with ROUNDS=4 -> next cycle in IDLE, in_ready=1, out_valid=0, data_out=00; no output for the aborted byte.
6. CIPHER_ABORT_EN defined: abort during ROUND -> IDLE next cycle, no out_valid. abort together with out_ready in DONE -> abort wins.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and helpers for the byte cipher sequencer.
package cipher_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int ROUNDS_MAX = 15;

  // Rotate by doubling the byte and keeping the upper half after the shift.
  function automatic logic [7:0] rotl8(input logic [7:0] data, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {data, data} << amount;
    return doubled[15:8];
  endfunction

endpackage

// File: rtl/substitution_block.sv
// Combinational 8-bit S-box used by every cipher round (AES inverse S-box table).
module substitution_block (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/cipher_round_ctrl.sv
// Multi-round byte cipher sequencer: accept, ROUNDS key-mix/substitute rounds, whiten, hand off.
// Optional abort input enabled by defining CIPHER_ABORT_EN.
module cipher_round_ctrl
  import cipher_pkg::*;
#(
  parameter int ROUNDS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] data_out,
  output logic       busy
`ifdef CIPHER_ABORT_EN
  ,
  input  logic       abort
`endif
);

  if (ROUNDS < 1 || ROUNDS > ROUNDS_MAX) begin : g_bad_rounds
    $error("cipher_round_ctrl: ROUNDS must be within 1..15");
  end

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [7:0] st_q, st_d;
  logic [7:0] k_q, k_d;
  logic [3:0] r_q, r_d;
  logic [7:0] data_out_q, data_out_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic [7:0] mix_byte;
  logic [7:0] sub_byte;
  logic       abort_req;

`ifdef CIPHER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign mix_byte = st_q ^ rotl8(k_q, r_q[2:0]);

  substitution_block u_sbox (
    .in_byte  (mix_byte),
    .out_byte (sub_byte)
  );

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    k_d         = k_q;
    r_d         = r_q;
    data_out_d  = data_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          st_d       = data_in;
          k_d        = key_in;
          r_d        = 4'd0;
          state_d    = ROUND;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ROUND: begin
        st_d = sub_byte;
        r_d  = r_q + 4'd1;
        if (r_q == LAST_ROUND) begin
          state_d     = DONE;
          data_out_d  = sub_byte ^ k_q;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase

    // Abort drops the byte in flight but leaves the last delivered result visible.
    if (abort_req && state_q != IDLE) begin
      state_d     = IDLE;
      st_d        = st_q;
      k_d         = k_q;
      r_d         = r_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
      busy_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      st_q        <= 8'h00;
      k_q         <= 8'h00;
      r_q         <= 4'd0;
      data_out_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      k_q         <= k_d;
      r_q         <= r_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Self-checking bench for cipher_round_ctrl: two instances (ROUNDS=1 and ROUNDS=4)
// checked against an S-box built from GF(2^8) arithmetic. Abort tests need CIPHER_ABORT_EN.
module tb_cipher_round_ctrl;

  localparam int R0 = 1;
  localparam int R1 = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] data_in   [2];
  logic [7:0] key_in    [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] data_out  [2];
  logic       busy      [2];
`ifdef CIPHER_ABORT_EN
  logic       abort     [2];
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [7:0] inv_sbox [256];

  always #5 clk = ~clk;

  cipher_round_ctrl #(.ROUNDS(R0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .data_in(data_in[0]), .key_in(key_in[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .data_out(data_out[0]), .busy(busy[0])
`ifdef CIPHER_ABORT_EN
    , .abort(abort[0])
`endif
  );

  cipher_round_ctrl #(.ROUNDS(R1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .data_in(data_in[1]), .key_in(key_in[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .data_out(data_out[1]), .busy(busy[1])
`ifdef CIPHER_ABORT_EN
    , .abort(abort[1])
`endif
  );

  function automatic int rounds_of(input int d);
    return (d == 0) ? R0 : R1;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = v << n;
    lo = v >> (8 - n);
    return hi | lo;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
    a = a_in;
    b = b_in;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    if (x == 8'h00) return 8'h00;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] model_cipher(input logic [7:0] din, input logic [7:0] kin, input int rounds);
    logic [7:0] st;
    st = din;
    for (int r = 0; r < rounds; r++) st = inv_sbox[st ^ rotl(kin, r % 8)];
    return st ^ kin;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One full transaction on instance d; stall>0 holds out_ready low for that many DONE cycles.
  task automatic applyStimulus(input int d, input logic [7:0] din, input logic [7:0] kin,
                               input logic [7:0] exp_out, input int stall);
    int cyc;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready[d], 1);
    in_valid[d]  = 1'b1;
    data_in[d]   = din;
    key_in[d]    = kin;
    out_ready[d] = (stall == 0);
    @(negedge clk);
    in_valid[d] = 1'b0;
    data_in[d]  = 8'($urandom);
    key_in[d]   = 8'($urandom);
    checkOutput("round_in_ready", in_ready[d], 0);
    checkOutput("round_busy", busy[d], 1);
    cyc = 1;
    while (!out_valid[d] && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("latency", cyc, rounds_of(d) + 1);
    checkOutput("data_out", data_out[d], exp_out);
    for (int s = 0; s < stall; s++) begin
      in_valid[d] = 1'b1;
      data_in[d]  = 8'($urandom);
      key_in[d]   = 8'($urandom);
      @(negedge clk);
      checkOutput("stall_valid", out_valid[d], 1);
      checkOutput("stall_data", data_out[d], exp_out);
      checkOutput("stall_in_ready", in_ready[d], 0);
    end
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    @(negedge clk);
    checkOutput("valid_drop", out_valid[d], 0);
    checkOutput("back_idle", in_ready[d], 1);
    checkOutput("busy_clear", busy[d], 0);
    checkOutput("data_held", data_out[d], exp_out);
    out_ready[d] = 1'($urandom);
  endtask

  task automatic count_quiet(input int d, input int cycles, input string tag);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid[d]) seen++;
    end
    checkOutput(tag, seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] din;
    logic [7:0] kin;
    logic [7:0] held;
    int d;

    for (int x = 0; x < 256; x++) inv_sbox[fwd_sbox(8'(x))] = 8'(x);

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      data_in[i]   = 8'h00;
      key_in[i]    = 8'h00;
      out_ready[i] = 1'b0;
`ifdef CIPHER_ABORT_EN
      abort[i]     = 1'b0;
`endif
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_in_ready", in_ready[i], 1);
      checkOutput("rst_out_valid", out_valid[i], 0);
      checkOutput("rst_busy", busy[i], 0);
      checkOutput("rst_data_out", data_out[i], 8'h00);
    end
    rst = 1'b0;

    applyStimulus(0, 8'h00, 8'h00, 8'h52, 0);
    applyStimulus(0, 8'h00, 8'h01, 8'h08, 0);
    applyStimulus(0, 8'h63, 8'h00, 8'h00, 0);
    applyStimulus(1, 8'h00, 8'h00, 8'h19, 0);
    din = 8'($urandom);
    kin = 8'($urandom);
    applyStimulus(1, din, kin, model_cipher(din, kin, R1), 10);

    for (int n = 0; n < 16; n++) begin
      d   = n % 2;
      din = 8'($urandom);
      kin = 8'($urandom);
      applyStimulus(d, din, kin, model_cipher(din, kin, rounds_of(d)), int'($urandom_range(0, 3)));
    end

    // Reset during the second round of a ROUNDS=4 byte.
    @(negedge clk);
    in_valid[1] = 1'b1;
    data_in[1]  = 8'($urandom);
    key_in[1]   = 8'($urandom);
    out_ready[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_in_ready", in_ready[1], 1);
    checkOutput("midrst_out_valid", out_valid[1], 0);
    checkOutput("midrst_busy", busy[1], 0);
    checkOutput("midrst_data_out", data_out[1], 8'h00);
    count_quiet(1, 8, "midrst_no_output");

`ifdef CIPHER_ABORT_EN
    din = 8'($urandom);
    kin = 8'($urandom);
    applyStimulus(1, din, kin, model_cipher(din, kin, R1), 0);
    held = model_cipher(din, kin, R1);
    @(negedge clk);
    in_valid[1] = 1'b1;
    data_in[1]  = 8'($urandom);
    key_in[1]   = 8'($urandom);
    @(negedge clk);
    in_valid[1] = 1'b0;
    @(negedge clk);
    abort[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    checkOutput("abort_in_ready", in_ready[1], 1);
    checkOutput("abort_out_valid", out_valid[1], 0);
    checkOutput("abort_data_held", data_out[1], held);
    count_quiet(1, 8, "abort_no_output");

    din = 8'($urandom);
    kin = 8'($urandom);
    held = model_cipher(din, kin, R1);
    @(negedge clk);
    in_valid[1]  = 1'b1;
    data_in[1]   = din;
    key_in[1]    = kin;
    out_ready[1] = 1'b0;
    @(negedge clk);
    in_valid[1] = 1'b0;
    repeat (R1) @(negedge clk);
    checkOutput("abort_done_valid", out_valid[1], 1);
    abort[1]     = 1'b1;
    out_ready[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    checkOutput("abort_done_drop", out_valid[1], 0);
    checkOutput("abort_done_idle", in_ready[1], 1);
    checkOutput("abort_done_data", data_out[1], held);
`else
    held = 8'h00;
    checkOutput("final_idle", in_ready[1], 1);
    checkOutput("final_data", data_out[1], held);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
